// File: rtl/agc_seq_core.sv
// rtl/agc_seq_core.sv - multi-cycle ones'-complement AGC-style sequencer core
module agc_seq_core #(
    parameter int WORD_W = 15,
    parameter int ADDR_W = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = 'o4000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [WORD_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              ext_out,
    output logic              ovf_out,
    output logic              halted
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC_RD,
        EXEC_WR,
        HALTED
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] K_RETURN = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] K_EXTEND = ADDR_W'(6);

    // Ones'-complement add: the carry out of the top bit wraps back into bit 0.
    function automatic logic [WORD_W-1:0] oc_add(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y);
        logic [WORD_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[WORD_W-1:0] + {{(WORD_W-1){1'b0}}, s[WORD_W]};
    endfunction

    // Diminished absolute value: |m| - 1, never below +0.
    function automatic logic [WORD_W-1:0] dabs(input logic [WORD_W-1:0] m);
        logic [WORD_W-1:0] mag;
        mag = m[WORD_W-1] ? ~m : m;
        return (mag == '0) ? '0 : mag - {{(WORD_W-1){1'b0}}, 1'b1};
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] q_q, q_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [WORD_W-1:0] m_q, m_d;
    logic              ext_q, ext_d;
    logic              ovf_q, ovf_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              halted_q, halted_d;

    logic [2:0]        opcode;
    logic [ADDR_W-1:0] k_field;
    logic [ADDR_W-1:0] pc_inc;
    logic [WORD_W-1:0] add_b;
    logic [WORD_W-1:0] add_sum;
    logic              add_ovf;
    logic [1:0]        ccs_skip;

    assign opcode  = ir_q[WORD_W-1 -: 3];
    assign k_field = ir_q[ADDR_W-1:0];
    assign pc_inc  = pc_q + PC_ONE;

    // Shared datapath: AD/SU adder with overflow, and the CCS four-way skip distance.
    always_comb begin
        add_b    = ext_q ? ~mem_rdata : mem_rdata;
        add_sum  = oc_add(a_q, add_b);
        add_ovf  = (a_q[WORD_W-1] == add_b[WORD_W-1]) && (add_sum[WORD_W-1] != a_q[WORD_W-1]);
        ccs_skip = 2'd0;
        if (mem_rdata == '0) begin
            ccs_skip = 2'd1;
        end else if (mem_rdata == '1) begin
            ccs_skip = 2'd3;
        end else if (mem_rdata[WORD_W-1]) begin
            ccs_skip = 2'd2;
        end
    end

    // Sequencer next-state: fetch, decode, operand read/write, each access held until acked.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        q_d         = q_q;
        a_d         = a_q;
        ir_d        = ir_q;
        m_d         = m_q;
        ext_d       = ext_q;
        ovf_d       = ovf_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        halted_d    = halted_q;
        case (state_q)
            FETCH: begin
                if (mem_rd_q && mem_ack) begin
                    ir_d     = mem_rdata;
                    mem_rd_d = 1'b0;
                    state_d  = DECODE;
                end else begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = pc_q;
                end
            end
            DECODE: begin
                if (!ext_q) begin
                    case (opcode)
                        3'd0: begin
                            if (k_field == K_RETURN) begin
                                pc_d = q_q;
                            end else if (k_field == K_EXTEND) begin
                                ext_d = 1'b1;
                                pc_d  = pc_inc;
                            end else begin
                                q_d  = pc_inc;
                                pc_d = k_field;
                            end
                            state_d = FETCH;
                        end
                        3'd2: begin
                            mem_wr_d    = 1'b1;
                            mem_addr_d  = k_field;
                            mem_wdata_d = a_q;
                            state_d     = EXEC_WR;
                        end
                        default: begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = k_field;
                            state_d    = EXEC_RD;
                        end
                    endcase
                end else if (opcode == 3'd0 && k_field == K_EXTEND) begin
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end else if (opcode == 3'd0) begin
                    halted_d = 1'b1;
                    state_d  = HALTED;
                end else if (opcode == 3'd6) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = k_field;
                    state_d    = EXEC_RD;
                end else begin
                    ext_d   = 1'b0;
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end
            EXEC_RD: begin
                if (mem_rd_q && mem_ack) begin
                    mem_rd_d = 1'b0;
                    ext_d    = 1'b0;
                    pc_d     = pc_inc;
                    state_d  = FETCH;
                    case (opcode)
                        3'd1: begin
                            a_d  = dabs(mem_rdata);
                            pc_d = pc_inc + {{(ADDR_W-2){1'b0}}, ccs_skip};
                        end
                        3'd3: begin
                            m_d         = mem_rdata;
                            mem_wr_d    = 1'b1;
                            mem_wdata_d = a_q;
                            pc_d        = pc_q;
                            state_d     = EXEC_WR;
                        end
                        3'd4: a_d = mem_rdata;
                        3'd5: a_d = ~mem_rdata;
                        3'd6: begin
                            a_d   = add_sum;
                            ovf_d = add_ovf;
                        end
                        3'd7: a_d = a_q & mem_rdata;
                        default: ;
                    endcase
                end
            end
            EXEC_WR: begin
                if (mem_wr_q && mem_ack) begin
                    mem_wr_d = 1'b0;
                    pc_d     = pc_inc;
                    state_d  = FETCH;
                    if (opcode == 3'd3) begin
                        a_d = m_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            q_q         <= '0;
            a_q         <= '0;
            ir_q        <= '0;
            m_q         <= '0;
            ext_q       <= 1'b0;
            ovf_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            q_q         <= q_d;
            a_q         <= a_d;
            ir_q        <= ir_d;
            m_q         <= m_d;
            ext_q       <= ext_d;
            ovf_q       <= ovf_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign acc_out   = a_q;
    assign pc_out    = pc_q;
    assign ext_out   = ext_q;
    assign ovf_out   = ovf_q;
    assign halted    = halted_q;

endmodule
